// File: rtl/cp0_pkg.sv
// Shared CP0 register indices, SR/Cause field positions and the exception vector.
// Used by cp0_ctrl, cp0_timer and the next-PC logic.
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  localparam int SR_IE       = 0;
  localparam int SR_EXL      = 1;
  localparam int SR_IM_LO    = 10;
  localparam int SR_IM_HI    = 15;
  localparam int CAUSE_IP_LO = 10;
  localparam int CAUSE_IP_HI = 15;

  localparam logic [31:0] PRID_DEFAULT = 32'h0000_0131;
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_3040;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer for CP0; ti is sticky until Compare is rewritten.
// Only instantiated when CP0_COUNT_EN is defined.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  sel,
  input  logic [31:0] din,
  input  logic        we,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic [31:0] count_reg;
  logic [31:0] count_next;
  logic [31:0] compare_reg;
  logic        ti_reg;

  always_comb begin
    count_next = count_reg + 32'd1;
    if (we && (sel == CP0_COUNT))
      count_next = din;
  end

  // Match against the value Count is about to hold so ti rises together with Count==Compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg   <= '0;
      compare_reg <= '0;
      ti_reg      <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (we && (sel == CP0_COMPARE)) begin
        compare_reg <= din;
        ti_reg      <= 1'b0;
      end else if ((compare_reg != 32'd0) && (count_next == compare_reg)) begin
        ti_reg <= 1'b1;
      end
    end
  end

  assign count   = count_reg;
  assign compare = compare_reg;
  assign ti      = ti_reg;

endmodule

// File: rtl/cp0_ctrl.sv
// Coprocessor-0: SR/Cause/EPC/PRId, mfc0/mtc0 port and interrupt request.
// Define CP0_COUNT_EN to add the Count/Compare timer on ip[15].
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = PRID_DEFAULT
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] pc,
  input  logic [4:0]  sel,
  input  logic [31:0] din,
  input  logic        we,
  input  logic        eret,
  input  logic [7:2]  hwint,
  output logic [31:0] dout,
  output logic [31:2] epc,
  output logic        intreq
);

  logic [5:0]  im_reg;
  logic [5:0]  ip_reg;
  logic        exl_reg;
  logic        ie_reg;
  logic [31:2] epc_reg;
  logic [5:0]  ip_view;
  logic        sr_wr;
  logic        epc_wr;

  assign sr_wr  = we && (sel == CP0_SR);
  assign epc_wr = we && (sel == CP0_EPC);

`ifdef CP0_COUNT_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;

  cp0_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .din     (din),
    .we      (we),
    .count   (count),
    .compare (compare),
    .ti      (ti)
  );

  assign ip_view = ip_reg | {ti, 5'b0};
`else
  assign ip_view = ip_reg;
`endif

  assign intreq = (|(ip_view & im_reg)) & ie_reg & ~exl_reg;

  // Taking the interrupt outranks eret and mtc0 for exl and EPC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_reg  <= '0;
      ip_reg  <= '0;
      exl_reg <= 1'b0;
      ie_reg  <= 1'b0;
      epc_reg <= '0;
    end else begin
      ip_reg <= hwint;
      if (sr_wr) begin
        im_reg <= din[SR_IM_HI:SR_IM_LO];
        ie_reg <= din[SR_IE];
      end
      if (intreq)
        exl_reg <= 1'b1;
      else if (eret)
        exl_reg <= 1'b0;
      else if (sr_wr)
        exl_reg <= din[SR_EXL];
      if (intreq)
        epc_reg <= pc;
      else if (epc_wr)
        epc_reg <= din[31:2];
    end
  end

  always_comb begin
    dout = '0;
    case (sel)
      CP0_SR: begin
        dout[SR_IM_HI:SR_IM_LO] = im_reg;
        dout[SR_EXL]            = exl_reg;
        dout[SR_IE]             = ie_reg;
      end
      CP0_CAUSE: dout[CAUSE_IP_HI:CAUSE_IP_LO] = ip_view;
      CP0_EPC:   dout = {epc_reg, 2'b00};
      CP0_PRID:  dout = PRID;
`ifdef CP0_COUNT_EN
      CP0_COUNT:   dout = count;
      CP0_COMPARE: dout = compare;
`endif
      default:   dout = '0;
    endcase
  end

  assign epc = epc_reg;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Scoreboard bench for cp0_ctrl: expectations queued with each stimulus, checked after the edge.
// Exercises the timer only when CP0_COUNT_EN is defined.
module tb_cp0_ctrl;
  import cp0_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:2] pc;
  logic [4:0]  sel;
  logic [31:0] din;
  logic        we;
  logic        eret;
  logic [7:2]  hwint;
  logic [31:0] dout;
  logic [31:2] epc;
  logic        intreq;

  always #5 clk = ~clk;

  cp0_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .pc     (pc),
    .sel    (sel),
    .din    (din),
    .we     (we),
    .eret   (eret),
    .hwint  (hwint),
    .dout   (dout),
    .epc    (epc),
    .intreq (intreq)
  );

  typedef enum {K_DOUT, K_EPC, K_INT} kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    logic [4:0]  rsel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic exp_dout(input string tag, input logic [4:0] s, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = K_DOUT; e.rsel = s; e.val = v;
    sb.push_back(e);
  endtask

  task automatic exp_epc(input string tag, input logic [29:0] v);
    exp_t e;
    e.tag = tag; e.kind = K_EPC; e.rsel = 5'd0; e.val = {2'b00, v};
    sb.push_back(e);
  endtask

  task automatic exp_int(input string tag, input logic v);
    exp_t e;
    e.tag = tag; e.kind = K_INT; e.rsel = 5'd0; e.val = {31'd0, v};
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    logic [4:0]  save;
    save = sel;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = '0;
      case (e.kind)
        K_DOUT: begin sel = e.rsel; #1; obs = dout; end
        K_EPC:  obs = {2'b00, epc};
        K_INT:  obs = {31'd0, intreq};
        default: obs = 'x;
      endcase
      check(e.tag, obs, e.val);
    end
    sel = save;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; eret = 1'b0; sel = 5'd0; din = '0;
  endtask

  task automatic mtc0(input logic [4:0] s, input logic [31:0] d);
    we = 1'b1; sel = s; din = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pc = '0; hwint = '0;
    idle();
    tick(); tick();
    exp_int("rst_int", 1'b0);
    exp_epc("rst_epc", 30'd0);
    drain();
    rst = 1'b0;
    exp_dout("rst_sr", CP0_SR, 32'h0);
    exp_dout("rst_prid", CP0_PRID, 32'h0000_0131);
    exp_dout("rst_unused", 5'd3, 32'h0);
    exp_int("rst_int2", 1'b0);
    exp_epc("rst_epc2", 30'd0);
    tick(); drain();

    // Take an interrupt on hwint[2]
    pc = 30'h0000_0C10; hwint = 6'b000001;
    mtc0(CP0_SR, 32'h0000_0401);
    exp_int("take_req", 1'b1);
    tick(); idle(); drain();
    exp_epc("take_epc", 30'h0000_0C10);
    exp_dout("take_sr", CP0_SR, 32'h0000_0403);
    exp_dout("take_cause", CP0_CAUSE, 32'h0000_0400);
    exp_int("take_drop", 1'b0);
    tick(); drain();

    // eret with the line still high re-raises the request
    eret = 1'b1; pc = 30'h0000_0C20;
    exp_int("eret_req", 1'b1);
    exp_dout("eret_sr", CP0_SR, 32'h0000_0401);
    exp_epc("eret_epc_hold", 30'h0000_0C10);
    tick(); idle(); drain();
    exp_epc("retake_epc", 30'h0000_0C20);
    exp_int("retake_drop", 1'b0);
    tick(); drain();

    // Take beats mtc0 EPC
    eret = 1'b1; pc = 30'h0000_0C30;
    exp_int("pri_req", 1'b1);
    tick(); idle(); drain();
    pc = 30'h0000_0C40;
    mtc0(CP0_EPC, 32'h0000_5000);
    exp_epc("pri_epc", 30'h0000_0C40);
    exp_dout("pri_sr", CP0_SR, 32'h0000_0403);
    exp_dout("pri_epc_rd", CP0_EPC, 32'h0000_3100);
    tick(); idle(); drain();

    // Take beats eret
    eret = 1'b1;
    exp_int("pri2_req", 1'b1);
    tick(); idle(); drain();
    eret = 1'b1; pc = 30'h0000_0C50;
    exp_epc("pri2_epc", 30'h0000_0C50);
    exp_dout("pri2_sr", CP0_SR, 32'h0000_0403);
    exp_int("pri2_drop", 1'b0);
    tick(); idle(); drain();

    // eret beats mtc0 SR for exl; im/ie still follow din
    eret = 1'b1;
    mtc0(CP0_SR, 32'h0000_0403);
    exp_dout("eret_mtc_sr", CP0_SR, 32'h0000_0401);
    exp_int("eret_mtc_int", 1'b1);
    tick(); idle(); drain();

    // mtc0 SR during a take: im/ie from din, exl forced to 1
    pc = 30'h0000_0C60;
    mtc0(CP0_SR, 32'h0000_0800);
    exp_dout("take_mtc_sr", CP0_SR, 32'h0000_0802);
    exp_epc("take_mtc_epc", 30'h0000_0C60);
    exp_int("take_mtc_int", 1'b0);
    tick(); idle(); drain();

    // Masking: all lines up, but im=0 or ie=0
    hwint = 6'h3F;
    mtc0(CP0_SR, 32'h0000_0001);
    tick(); idle();
    for (int i = 0; i < 5; i++) begin
      exp_int($sformatf("mask_im_%0d", i), 1'b0);
      tick(); drain();
    end
    mtc0(CP0_SR, 32'h0000_FC00);
    tick(); idle();
    for (int i = 0; i < 5; i++) begin
      exp_int($sformatf("mask_ie_%0d", i), 1'b0);
      tick(); drain();
    end
    mtc0(CP0_SR, 32'h0000_FC01);
    exp_int("unmask_req", 1'b1);
    exp_dout("unmask_cause", CP0_CAUSE, 32'h0000_FC00);
    tick(); idle(); drain();

    // Reset in the middle of a handler clears everything at once
    tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_int("midrst_int", 1'b0);
    exp_dout("midrst_sr", CP0_SR, 32'h0);
    exp_dout("midrst_cause", CP0_CAUSE, 32'h0);
    exp_epc("midrst_epc", 30'd0);
    drain();
    tick();
    rst = 1'b0;
    exp_int("postrst_int", 1'b0);
    exp_dout("postrst_cause", CP0_CAUSE, 32'h0000_FC00);
    tick(); drain();

    // mtc0 EPC, ignored registers, no same-cycle bypass
    mtc0(CP0_EPC, 32'h1234_5677);
    exp_dout("wr_epc_rd", CP0_EPC, 32'h1234_5674);
    exp_epc("wr_epc", 30'h048D_159D);
    tick(); idle(); drain();
    mtc0(5'd3, 32'hFFFF_FFFF);
    exp_dout("wr_ign", 5'd3, 32'h0);
    tick(); idle(); drain();
    mtc0(CP0_SR, 32'h0000_0400);
    #1;
    check("no_bypass", dout, 32'h0);
    exp_dout("wr_sr_next", CP0_SR, 32'h0000_0400);
    tick(); idle(); drain();

`ifdef CP0_COUNT_EN
    begin
      bit found;
      hwint = '0;
      mtc0(CP0_SR, 32'h0);
      tick();
      mtc0(CP0_COMPARE, 32'd5);
      tick();
      mtc0(CP0_COUNT, 32'd0);
      tick();
      mtc0(CP0_SR, 32'h0000_8001);
      tick(); idle();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        if (intreq) found = 1'b1;
        else tick();
      end
      if (!found) begin
        check("tmr_wait", 32'd0, 32'd1);
      end else begin
        exp_dout("tmr_count", CP0_COUNT, 32'd5);
        exp_dout("tmr_cause", CP0_CAUSE, 32'h0000_8000);
        drain();
        mtc0(CP0_COMPARE, 32'h20);
        exp_dout("tmr_ti_clr", CP0_CAUSE, 32'h0);
        exp_int("tmr_int_clr", 1'b0);
        tick(); idle(); drain();
      end
    end
`else
    mtc0(CP0_COUNT, 32'h1234_0000);
    exp_dout("no_count", CP0_COUNT, 32'h0);
    tick(); idle(); drain();
    mtc0(CP0_COMPARE, 32'h0000_0005);
    exp_dout("no_compare", CP0_COMPARE, 32'h0);
    tick(); idle(); drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
